cla_pipelined_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder with valid/ready flow control.

---
 rtl/cla_pkg.sv | 46 ++++
 rtl/cla_group.sv | 33 +++
 rtl/cla_pipelined_adder.sv | 185 ++++++++++++++++++
 tb/tb_cla_pipelined_adder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
// Group/stage partition helpers are pure functions so every file derives the same boundaries.
package cla_pkg;

    localparam int MAX_BLOCK = 64;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Combined generate/propagate over the low n bits of g/p (bit 0 is least significant).
    function automatic gp_t grp_gp(input logic [MAX_BLOCK-1:0] g,
                                   input logic [MAX_BLOCK-1:0] p,
                                   input int n);
        gp_t r;
        r.g = 1'b0;
        r.p = 1'b1;
        for (int i = 0; i < MAX_BLOCK; i++) begin
            if (i < n) begin
                r.g = g[i] | (p[i] & r.g);
                r.p = r.p & p[i];
            end
        end
        return r;
    endfunction

    function automatic int num_groups(input int width, input int block);
        return width / block;
    endfunction

    // First group resolved by stage s; stage_lo(stages, ...) equals ngrp.
    function automatic int stage_lo(input int s, input int ngrp, input int stages);
        return (s * ngrp) / stages;
    endfunction

    function automatic int grp_stage(input int gi, input int ngrp, input int stages);
        int r;
        r = 0;
        for (int s = 0; s < stages; s++) begin
            if (gi >= stage_lo(s, ngrp, stages)) r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit lookahead group: per-bit carries from prefix g/p, plus group Gg/Pg.
module cla_group
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] g,
    input  logic [BLOCK-1:0] p,
    input  logic             ci,
    output logic [BLOCK-1:0] c,
    output logic             gg,
    output logic             pg
);

    logic [MAX_BLOCK-1:0] g_ext;
    logic [MAX_BLOCK-1:0] p_ext;
    gp_t                  all_gp;

    assign g_ext = MAX_BLOCK'(g);
    assign p_ext = MAX_BLOCK'(p);

    // Each carry is a flat prefix term over bits [gi:0], not a ripple through c[gi-1].
    for (genvar gi = 0; gi < BLOCK; gi++) begin : g_bit
        gp_t pre;
        assign pre   = grp_gp(g_ext, p_ext, gi + 1);
        assign c[gi] = pre.g | (pre.p & ci);
    end

    assign all_gp = grp_gp(g_ext, p_ext, BLOCK);
    assign gg     = all_gp.g;
    assign pg     = all_gp.p;

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder with valid/ready flow control over STAGES register stages.
// Optional signed-overflow output ovf is built when CLA_OVF_EN is defined.
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NGRP = num_groups(WIDTH, BLOCK);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  g_q   [STAGES];
    logic [WIDTH-1:0]  p_q   [STAGES];
    logic [WIDTH-1:0]  g_src [STAGES];
    logic [WIDTH-1:0]  p_src [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  g_in;
    logic [WIDTH-1:0]  p_in;

    logic [BLOCK-1:0]  grp_c   [NGRP];
    logic [BLOCK-1:0]  grp_sum [NGRP];
    logic              grp_ci  [NGRP];
    logic              grp_co  [NGRP];
    logic              grp_gg  [NGRP];
    logic              grp_pg  [NGRP];

    assign g_in = a & b;
    assign p_in = a ^ b;

    // A stage's first group takes its carry from the previous stage's register; later groups chain on Gg/Pg.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int GS = grp_stage(gi, NGRP, STAGES);
        localparam int LO = stage_lo(GS, NGRP, STAGES);
        logic [BLOCK-1:0] g_s;
        logic [BLOCK-1:0] p_s;
        logic [BLOCK-1:0] c_prev;

        if (GS == 0) begin : g_from_in
            assign g_s = g_in[gi*BLOCK +: BLOCK];
            assign p_s = p_in[gi*BLOCK +: BLOCK];
        end else begin : g_from_reg
            assign g_s = g_q[GS-1][gi*BLOCK +: BLOCK];
            assign p_s = p_q[GS-1][gi*BLOCK +: BLOCK];
        end

        if (gi == LO) begin : g_ci_stage
            if (GS == 0) begin : g_ci_cin
                assign grp_ci[gi] = cin;
            end else begin : g_ci_reg
                assign grp_ci[gi] = carry_q[GS-1];
            end
        end else begin : g_ci_chain
            assign grp_ci[gi] = grp_co[gi-1];
        end

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .g  (g_s),
            .p  (p_s),
            .ci (grp_ci[gi]),
            .c  (grp_c[gi]),
            .gg (grp_gg[gi]),
            .pg (grp_pg[gi])
        );

        assign grp_co[gi] = grp_gg[gi] | (grp_pg[gi] & grp_ci[gi]);

        if (BLOCK == 1) begin : g_cprev_1
            assign c_prev = grp_ci[gi];
        end else begin : g_cprev_n
            assign c_prev = {grp_c[gi][BLOCK-2:0], grp_ci[gi]};
        end
        assign grp_sum[gi] = p_s ^ c_prev;
    end

    // Ready propagates back from out_ready so a full pipe can accept and emit in the same cycle.
    always_comb begin
        logic nxt;
        nxt  = out_ready;
        en   = '0;
        up_v = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en[k] = ~v_q[k] | nxt;
            nxt   = en[k];
        end
        up_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v_q[k-1];
        end
        ld = en & up_v;
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            int prv;
            prv = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                g_src[s] = g_in;
                p_src[s] = p_in;
                sum_d[s] = '0;
            end else begin
                g_src[s] = g_q[prv];
                p_src[s] = p_q[prv];
                sum_d[s] = sum_q[prv];
            end
            for (int gi = 0; gi < NGRP; gi++) begin
                if (grp_stage(gi, NGRP, STAGES) == s) sum_d[s][gi*BLOCK +: BLOCK] = grp_sum[gi];
            end
            carry_d[s] = grp_co[stage_lo(s + 1, NGRP, STAGES) - 1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            carry_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (en[s]) v_q[s] <= up_v[s];
                if (ld[s]) begin
                    g_q[s]     <= g_src[s];
                    p_q[s]     <= p_src[s];
                    sum_q[s]   <= sum_d[s];
                    carry_q[s] <= carry_d[s];
                end
            end
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q;
    logic ovf_d;
    logic c_wm2;

    if (BLOCK >= 2) begin : g_wm2_in_grp
        assign c_wm2 = grp_c[NGRP-1][BLOCK-2];
    end else begin : g_wm2_ci
        assign c_wm2 = grp_ci[NGRP-1];
    end
    assign ovf_d = grp_c[NGRP-1][BLOCK-1] ^ c_wm2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ld[STAGES-1]) begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`endif

    assign in_ready  = en[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Directed and scoreboarded checks of cla_pipelined_adder at (32,4,2) and (64,4,3).
// ovf is checked only when CLA_OVF_EN is defined.
module tb_cla_pipelined_adder;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int W2 = 64;
    localparam int S2 = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0]  a, b, sum;
    logic          in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2;
    logic [W2-1:0] a2, b2, sum2;
`ifdef CLA_OVF_EN
    logic          ovf, ovf2;
`endif

    always #5 clk = ~clk;

    cla_pipelined_adder #(.WIDTH(W), .BLOCK(4), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CLA_OVF_EN
        , .ovf(ovf)
`endif
    );

    cla_pipelined_adder #(.WIDTH(W2), .BLOCK(4), .STAGES(S2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2)
`ifdef CLA_OVF_EN
        , .ovf(ovf2)
`endif
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          sent1 = 0, emitted1 = 0, sent2 = 0, emitted2 = 0;
    bit          lat_chk = 1'b1;
    logic [63:0] e_sum, e_sum2;
    logic        e_cout, e_ovf, e_cout2, e_ovf2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                exp_t e;
                emitted1++;
                chk("out_has_expected", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("sum", 64'(sum), e.sum);
                    chk("cout", 64'(cout), 64'(e.cout));
`ifdef CLA_OVF_EN
                    chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
                    if (lat_chk) chk("latency", 64'(cyc - e.t), 64'(S));
                    $display("txn %0d: sum=%h cout=%b", emitted1, sum, cout);
                end
            end
            if (in_valid && in_ready) q1.push_back('{e_sum, e_cout, e_ovf, cyc});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid2 && out_ready2) begin
                exp_t e;
                emitted2++;
                chk("w64_out_has_expected", 64'(q2.size() > 0), 64'd1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    chk("w64_sum", sum2, e.sum);
                    chk("w64_cout", 64'(cout2), 64'(e.cout));
`ifdef CLA_OVF_EN
                    chk("w64_ovf", 64'(ovf2), 64'(e.ovf));
`endif
                    $display("txn w64 %0d: sum=%h cout=%b", emitted2, sum2, cout2);
                end
            end
            if (in_valid2 && in_ready2) q2.push_back('{e_sum2, e_cout2, e_ovf2, cyc});
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic [31:0] es, input logic ec, input logic eo);
        logic got;
        int   n;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        e_sum = 64'(es); e_cout = ec; e_ovf = eo;
        got = 1'b0;
        n   = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (got) sent1++;
        else chk("accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic send_rand();
        logic [31:0] ra, rb, rs;
        logic        rc, rco;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
        {rco, rs} = {1'b0, ra} + {1'b0, rb} + 33'(rc);
        send(ra, rb, rc, rs, rco, (ra[31] == rb[31]) && (rs[31] != ra[31]));
    endtask

    task automatic send2(input logic [63:0] va, input logic [63:0] vb, input logic vc);
        logic [63:0] rs;
        logic        rco, got;
        int          n;
        {rco, rs} = {1'b0, va} + {1'b0, vb} + 65'(vc);
        a2 = va; b2 = vb; cin2 = vc; in_valid2 = 1'b1;
        e_sum2 = rs; e_cout2 = rco; e_ovf2 = (va[63] == vb[63]) && (rs[63] != va[63]);
        got = 1'b0;
        n   = 0;
        while (!got && n < 50) begin
            out_ready2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            got = in_ready2;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid2 = 1'b0;
        if (got) sent2++;
        else chk("w64_accept_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 32'd5; b = 32'd6; cin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; cin2 = 1'b0;
        e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_sum2 = '0; e_cout2 = 1'b0; e_ovf2 = 1'b0;

        // Reset held with in_valid asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
`ifdef CLA_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Full-width ripple across the stage boundary, with explicit latency check
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ripple_not_yet_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ripple_valid_at_2", 64'(out_valid), 64'd1);
        chk("ripple_sum", 64'(sum), 64'd0);
        chk("ripple_cout", 64'(cout), 64'd1);
        @(posedge clk); #1;

        send(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
        send(32'h0000_FFFF, 32'h1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (4) begin @(posedge clk); #1; end

        // Back-to-back burst: one accept per cycle
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 100; i++) send_rand();
            chk("burst_throughput", 64'(cyc - c0), 64'd100);
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("burst_all_emitted", 64'(emitted1), 64'(sent1));

        // Full pipe stalled by out_ready=0
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
        send(32'h0000_0100, 32'h0000_0200, 1'b1, 32'h0000_0301, 1'b0, 1'b0);
        a = 32'hF000_0000; b = 32'h2000_0000; cin = 1'b0; in_valid = 1'b1;
        e_sum = 64'h1000_0000; e_cout = 1'b1; e_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_sum_held", 64'(sum), 64'h30);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("accept_and_emit", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sent1++;
        @(negedge clk);
        chk("occupancy_kept", 64'(out_valid), 64'd1);
        repeat (4) begin @(posedge clk); #1; end
        chk("stall_no_loss", 64'(emitted1), 64'(sent1));
        chk("stall_queue_empty", 64'(q1.size()), 64'd0);
        lat_chk = 1'b1;

        // 64-bit, 3-stage build with random backpressure
        send2(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        send2(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        for (int i = 0; i < 40; i++) send2({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        out_ready2 = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("w64_all_emitted", 64'(emitted2), 64'(sent2));
        chk("w64_queue_empty", 64'(q2.size()), 64'd0);

        // Reset with two adds in flight
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h2, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h7, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_flush_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flush_sum", 64'(sum), 64'd0);
        q1.delete();
        sent1 = 0;
        emitted1 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk("post_rst_nothing_emitted", 64'(emitted1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
